facerecog_window_scheduler: RTL and testbench

- Sequences CLASSIFIER_kernel across a whole frame.
- Walks a 20x20 window over the frame's integral image in raster order.
- Per window: loads the window into the kernel through its address_i/address_j/read_write port, restarts the kernel, then waits for a pass/fail verdict.
- Reports detected window coordinates on a valid/ready output; sits between the integral-image frame memory and the kernel.

---
 rtl/facerecog_window_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_facerecog_window_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/facerecog_window_scheduler.sv
// Raster-scans a WINxWIN window over the integral image, loads each window into the
// classifier kernel, and reports detected windows. Optional watchdog: FACERECOG_SCHED_TIMEOUT_EN.
module facerecog_window_scheduler #(
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int WIN         = 20,
    parameter int STEP        = 4,
    parameter int DATA_W      = 17,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [9:0]        mem_x,
    output logic [8:0]        mem_y,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              k_reset_n,
    output logic [DATA_W-1:0] k_integral_input,
    output logic [4:0]        k_address_i,
    output logic [4:0]        k_address_j,
    output logic              k_read_write,
    output logic              k_in_valid,
    output logic              k_out_ready,
    output logic [9:0]        k_pos_x,
    output logic [8:0]        k_pos_y,
    input  logic              k_out_valid,
    input  logic              k_detected,
    input  logic              k_failed,
    output logic              det_valid,
    output logic [9:0]        det_x,
    output logic [8:0]        det_y,
    input  logic              det_ready,
    output logic [15:0]       det_count,
    output logic              timeout_err
);
    // Last scanned origin: largest multiple of STEP that still fits a whole window.
    localparam logic [9:0] X_LAST   = 10'(((IMG_W - WIN) / STEP) * STEP);
    localparam logic [8:0] Y_LAST   = 9'(((IMG_H - WIN) / STEP) * STEP);
    localparam logic [4:0] IDX_LAST = 5'(WIN - 1);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, REPORT, ADVANCE, DONE} state_t;
    state_t state_reg, state_next;

    logic [9:0]  win_x_reg;
    logic [8:0]  win_y_reg;
    logic [4:0]  rd_i_reg, rd_j_reg, wr_i_reg, wr_j_reg;
    logic        rd_done_reg, wr_valid_reg, arm_phase_reg;
    logic [15:0] det_count_reg;
    logic        rd_en, verdict, timeout_hit;

    assign verdict = k_out_valid && (k_detected || k_failed);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        busy        = 1'b1;
        done        = 1'b0;
        rd_en       = 1'b0;
        k_reset_n   = 1'b0;
        k_out_ready = 1'b0;
        det_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                rd_en = !rd_done_reg;
                if (rd_done_reg) state_next = ARM;
            end
            ARM: begin
                if (arm_phase_reg) begin
                    k_reset_n   = 1'b1;
                    k_out_ready = 1'b1;
                    state_next  = RUN;
                end
            end
            RUN: begin
                k_reset_n   = 1'b1;
                k_out_ready = 1'b1;
                // Detected wins when the kernel raises both flags.
                if (verdict)          state_next = k_detected ? REPORT : ADVANCE;
                else if (timeout_hit) state_next = ADVANCE;
            end
            REPORT: begin
                det_valid = 1'b1;
                if (det_ready) state_next = ADVANCE;
            end
            ADVANCE: state_next = (win_x_reg < X_LAST || win_y_reg < Y_LAST) ? LOAD : DONE;
            DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            win_x_reg     <= '0;
            win_y_reg     <= '0;
            rd_i_reg      <= '0;
            rd_j_reg      <= '0;
            rd_done_reg   <= 1'b0;
            wr_i_reg      <= '0;
            wr_j_reg      <= '0;
            wr_valid_reg  <= 1'b0;
            arm_phase_reg <= 1'b0;
            det_count_reg <= '0;
        end else begin
            // Write side trails the read side by the one-cycle memory latency.
            wr_valid_reg  <= rd_en;
            wr_i_reg      <= rd_i_reg;
            wr_j_reg      <= rd_j_reg;
            arm_phase_reg <= (state_reg == ARM) && !arm_phase_reg;

            if (state_reg != LOAD) begin
                rd_i_reg    <= '0;
                rd_j_reg    <= '0;
                rd_done_reg <= 1'b0;
            end else if (rd_en) begin
                if (rd_j_reg == IDX_LAST) begin
                    rd_j_reg <= '0;
                    if (rd_i_reg == IDX_LAST) rd_done_reg <= 1'b1;
                    else                      rd_i_reg    <= rd_i_reg + 5'd1;
                end else begin
                    rd_j_reg <= rd_j_reg + 5'd1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        win_x_reg     <= '0;
                        win_y_reg     <= '0;
                        det_count_reg <= '0;
                    end
                end
                REPORT: begin
                    if (det_ready && det_count_reg != 16'hFFFF)
                        det_count_reg <= det_count_reg + 16'd1;
                end
                ADVANCE: begin
                    if (win_x_reg < X_LAST) begin
                        win_x_reg <= win_x_reg + 10'(STEP);
                    end else if (win_y_reg < Y_LAST) begin
                        win_x_reg <= '0;
                        win_y_reg <= win_y_reg + 9'(STEP);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en        = rd_en;
    assign mem_x            = rd_en ? win_x_reg + {5'd0, rd_j_reg} : '0;
    assign mem_y            = rd_en ? win_y_reg + {4'd0, rd_i_reg} : '0;
    assign k_in_valid       = wr_valid_reg;
    assign k_read_write     = wr_valid_reg;
    assign k_integral_input = wr_valid_reg ? mem_rd_data : '0;
    assign k_address_i      = wr_valid_reg ? wr_i_reg : '0;
    assign k_address_j      = wr_valid_reg ? wr_j_reg : '0;
    assign k_pos_x          = win_x_reg;
    assign k_pos_y          = win_y_reg;
    assign det_x            = det_valid ? win_x_reg : '0;
    assign det_y            = det_valid ? win_y_reg : '0;
    assign det_count        = det_count_reg;

`ifdef FACERECOG_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_err_reg;

    assign timeout_hit = (state_reg == RUN) && (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == RUN) wd_cnt_reg <= wd_cnt_reg + 1'b1;
            else                  wd_cnt_reg <= '0;
            if (state_reg == IDLE && start)  timeout_err_reg <= 1'b0;
            else if (timeout_hit && !verdict) timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_facerecog_window_scheduler.sv
// Scoreboard bench for facerecog_window_scheduler on a 24x22 frame with STEP=2 (six windows).
module tb_facerecog_window_scheduler;
    localparam int DW = 17;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, mem_rd_en;
    logic [9:0]    mem_x;
    logic [8:0]    mem_y;
    logic [DW-1:0] mem_rd_data = '0;
    logic          k_reset_n;
    logic [DW-1:0] k_integral_input;
    logic [4:0]    k_address_i, k_address_j;
    logic          k_read_write, k_in_valid, k_out_ready;
    logic [9:0]    k_pos_x;
    logic [8:0]    k_pos_y;
    logic          k_out_valid = 1'b0, k_detected = 1'b0, k_failed = 1'b0;
    logic          det_valid;
    logic [9:0]    det_x;
    logic [8:0]    det_y;
    logic          det_ready = 1'b1;
    logic [15:0]   det_count;
    logic          timeout_err;

    facerecog_window_scheduler #(
        .IMG_W(24), .IMG_H(22), .WIN(20), .STEP(2), .DATA_W(DW), .TIMEOUT_CYC(200)
    ) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_x(mem_x), .mem_y(mem_y), .mem_rd_data(mem_rd_data),
        .k_reset_n(k_reset_n), .k_integral_input(k_integral_input),
        .k_address_i(k_address_i), .k_address_j(k_address_j),
        .k_read_write(k_read_write), .k_in_valid(k_in_valid), .k_out_ready(k_out_ready),
        .k_pos_x(k_pos_x), .k_pos_y(k_pos_y), .k_out_valid(k_out_valid),
        .k_detected(k_detected), .k_failed(k_failed),
        .det_valid(det_valid), .det_x(det_x), .det_y(det_y), .det_ready(det_ready),
        .det_count(det_count), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Frame memory: data = (y<<5)|x, one cycle after the strobe.
    always @(posedge CLK)
        if (mem_rd_en) mem_rd_data <= (DW'(mem_y) << 5) | DW'(mem_x);

    // Kernel: verdict 50 cycles after release; detects only the selected window.
    int         kcnt = 0;
    logic       det_en = 1'b0, silent_en = 1'b0;
    logic [9:0] det_wx = '0, silent_wx = '0;
    logic [8:0] det_wy = '0, silent_wy = '0;
    always @(posedge CLK) begin
        if (!k_reset_n) begin
            kcnt        <= 0;
            k_out_valid <= 1'b0;
            k_detected  <= 1'b0;
            k_failed    <= 1'b0;
        end else begin
            kcnt <= kcnt + 1;
            if (kcnt == 49 && !(silent_en && k_pos_x == silent_wx && k_pos_y == silent_wy)) begin
                k_out_valid <= 1'b1;
                k_detected  <= det_en && k_pos_x == det_wx && k_pos_y == det_wy;
                k_failed    <= !(det_en && k_pos_x == det_wx && k_pos_y == det_wy);
            end
        end
    end

    typedef struct packed { logic [9:0] x; logic [8:0] y; } win_t;
    typedef struct packed {
        logic [9:0] wx; logic [8:0] wy; logic [4:0] i; logic [4:0] j; logic [DW-1:0] d;
    } wr_t;

    win_t exp_win_q[$];
    win_t exp_det_q[$];
    wr_t  exp_wr_q[$];

    task automatic push_frame();
        for (int wy = 0; wy <= 2; wy += 2)
            for (int wx = 0; wx <= 4; wx += 2) begin
                exp_win_q.push_back('{x: 10'(wx), y: 9'(wy)});
                for (int i = 0; i < 20; i++)
                    for (int j = 0; j < 20; j++)
                        exp_wr_q.push_back('{wx: 10'(wx), wy: 9'(wy), i: 5'(i), j: 5'(j),
                                             d: DW'(((wy + i) << 5) | (wx + j))});
            end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a kernel start or a record.
    int            rd_seen = 0, done_seen = 0;
    logic          prev_krn = 1'b0, prev_dv = 1'b0, prev_dr = 1'b0;
    logic [9:0]    prev_dx = '0;
    logic [8:0]    prev_dy = '0;
    logic [DW-1:0] probe_data = '0;
    wr_t           mon_wr;
    win_t          mon_win;

    always @(negedge CLK) begin
        if (!RESET) begin
            prev_krn = 1'b0;
            prev_dv  = 1'b0;
            prev_dr  = 1'b0;
        end else begin
            if (mem_rd_en) rd_seen++;
            if (done) done_seen++;
            if (k_in_valid) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got write i=%0d j=%0d required none", k_address_i, k_address_j);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    check("k_read_write_load", k_read_write, 1);
                    check("k_address_i", k_address_i, mon_wr.i);
                    check("k_address_j", k_address_j, mon_wr.j);
                    check("k_integral_input", k_integral_input, mon_wr.d);
                    if (mon_wr.wx == 2 && mon_wr.wy == 2 && mon_wr.i == 3 && mon_wr.j == 5)
                        probe_data = k_integral_input;
                end
            end
            if (k_reset_n && !prev_krn) begin
                if (exp_win_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL win_unexpected: got window (%0d,%0d) required none", k_pos_x, k_pos_y);
                end else begin
                    mon_win = exp_win_q.pop_front();
                    check("k_pos_x", k_pos_x, mon_win.x);
                    check("k_pos_y", k_pos_y, mon_win.y);
                    check("k_read_write_run", k_read_write, 0);
                end
            end
            if (prev_dv && !prev_dr) begin
                check("det_valid_hold", det_valid, 1);
                check("det_x_hold", det_x, prev_dx);
                check("det_y_hold", det_y, prev_dy);
            end
            if (det_valid && det_ready) begin
                if (exp_det_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL det_unexpected: got (%0d,%0d) required none", det_x, det_y);
                end else begin
                    mon_win = exp_det_q.pop_front();
                    check("det_x", det_x, mon_win.x);
                    check("det_y", det_y, mon_win.y);
                end
            end
            prev_krn = k_reset_n;
            prev_dv  = det_valid;
            prev_dr  = det_ready;
            prev_dx  = det_x;
            prev_dy  = det_y;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20000) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: got no done after %0d cycles required done", name, n);
        end
        tick();
        tick();
    endtask

    task automatic frame_end(input string name, input int done_base, input int rd_base, input int exp_count);
        check({name, "_done_pulses"}, done_seen - done_base, 1);
        check({name, "_rd_strobes"}, rd_seen - rd_base, 2400);
        check({name, "_det_count"}, det_count, exp_count);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_win_left"}, exp_win_q.size(), 0);
        check({name, "_wr_left"}, exp_wr_q.size(), 0);
        check({name, "_det_left"}, exp_det_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, {busy, done, mem_rd_en, k_reset_n, k_read_write, k_in_valid,
                                k_out_ready, det_valid, timeout_err}, 0);
        check({name, "_det_count"}, det_count, 0);
        check({name, "_addr_data"}, {mem_x, mem_y, k_integral_input, k_address_i, k_address_j}, 0);
        check({name, "_pos_det"}, {k_pos_x, k_pos_y, det_x, det_y}, 0);
    endtask

    initial begin
        int db, rb, n, stall_rd, hi;

        tick();
        tick();
        check_reset_outputs("reset_hold");
        RESET = 1'b1;
        tick();
        check_reset_outputs("reset_release");

        // Frame 1: every window fails.
        push_frame();
        db = done_seen; rb = rd_seen;
        pulse_start();
        check("f1_busy", busy, 1);
        wait_done("f1");
        frame_end("f1", db, rb, 0);
        check("f1_probe_2_2_i3_j5", probe_data, 17'd167);
        check("f1_timeout_err", timeout_err, 0);

        // Frame 2: only (4,0) detects; a start mid-scan must be ignored.
        det_en = 1'b1; det_wx = 10'd4; det_wy = 9'd0;
        push_frame();
        exp_det_q.push_back('{x: 10'd4, y: 9'd0});
        db = done_seen; rb = rd_seen;
        pulse_start();
        repeat (700) tick();
        check("f2_busy_mid", busy, 1);
        pulse_start();
        wait_done("f2");
        frame_end("f2", db, rb, 1);

        // Frame 3: detect at (0,2) under 100 cycles of backpressure.
        det_wx = 10'd0; det_wy = 9'd2;
        det_ready = 1'b0;
        push_frame();
        exp_det_q.push_back('{x: 10'd0, y: 9'd2});
        db = done_seen; rb = rd_seen;
        pulse_start();
        n = 0;
        while (!det_valid && n < 20000) begin
            tick();
            n++;
        end
        check("f3_det_valid_seen", det_valid, 1);
        stall_rd = 0;
        for (int c = 0; c < 100; c++) begin
            if (mem_rd_en) stall_rd++;
            tick();
        end
        check("f3_stall_rd", stall_rd, 0);
        check("f3_det_valid_stall", det_valid, 1);
        det_ready = 1'b1;
        wait_done("f3");
        frame_end("f3", db, rb, 1);
        det_en = 1'b0;

        // Reset during read 150 of window (2,0), i.e. strobe 550 of the frame.
        push_frame();
        rb = rd_seen;
        pulse_start();
        n = 0;
        while (!(rd_seen - rb == 550 && mem_rd_en) && n < 20000) begin
            tick();
            n++;
        end
        check("rst_reached_read", rd_seen - rb, 550);
        RESET = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_win_q.delete();
        exp_wr_q.delete();
        exp_det_q.delete();
        tick();
        tick();
        RESET = 1'b1;
        tick();
        push_frame();
        db = done_seen; rb = rd_seen;
        pulse_start();
        wait_done("f4");
        frame_end("f4", db, rb, 0);

`ifdef FACERECOG_SCHED_TIMEOUT_EN
        // Kernel stays silent on (2,2): the watchdog must end RUN after 200 cycles.
        silent_en = 1'b1; silent_wx = 10'd2; silent_wy = 9'd2;
        push_frame();
        db = done_seen; rb = rd_seen;
        pulse_start();
        n = 0;
        while (!(k_reset_n && k_pos_x == 10'd2 && k_pos_y == 9'd2) && n < 20000) begin
            tick();
            n++;
        end
        check("to_timeout_err_before", timeout_err, 0);
        hi = 0;
        while (k_reset_n && hi < 1000) begin
            hi++;
            tick();
        end
        check("to_release_cycles", hi, 201);
        check("to_timeout_err_set", timeout_err, 1);
        wait_done("f5");
        frame_end("f5", db, rb, 0);
        check("to_timeout_err_sticky", timeout_err, 1);
        silent_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
